// File: rtl/riscv_pkg.sv
// Shared RISC-V constants: canonical NOP, base opcodes and the default PC width.
package riscv_pkg;

  localparam int          XLEN = 64;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  function automatic logic [6:0] opcodeOf(input logic [31:0] instr);
    return instr[6:0];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer of {pc, instr} entries with push, pop, flush and occupancy count.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 96
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             pushData,
  input  logic                         pop,
  input  logic                         flush,
  output logic [WIDTH-1:0]             headData,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;

  // Storage needs no reset; only the pointers and count define validity.
  always_ff @(posedge clock) begin
    if (push && !flush && !reset) begin
      mem[tail] <= pushData;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  assign headData = mem[head];

endmodule

// File: rtl/riscv_fetch_queue.sv
// Fetch front end: credit-limited in-order word fetches, prefetch queue, IF/ID register with redirect flush.
module riscv_fetch_queue #(
  parameter int               DEPTH    = 4,
  parameter int               XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic             clock,
  input  logic             reset,
  output logic             imem_req_valid,
  output logic [XLEN-1:0]  imem_req_addr,
  input  logic             imem_req_ready,
  input  logic             imem_resp_valid,
  input  logic [31:0]      imem_resp_data,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic [31:0]      ifid_ir,
  output logic [XLEN-1:0]  ifid_pc,
  output logic             ifid_valid
);

  import riscv_pkg::*;

  localparam int          CW  = $clog2(DEPTH+1);
  localparam logic [CW:0] CAP = (CW+1)'(DEPTH);

  logic [XLEN-1:0]    fetchPc;
  logic [CW-1:0]      inflight;
  logic [CW-1:0]      discard;
  logic [CW-1:0]      count;
  logic [XLEN+31:0]   headData;
  logic [XLEN-1:0]    respPc;
  logic               accept;
  logic               respKeep;
  logic               pop;
  logic               unusedRedirectBits;

  assign unusedRedirectBits = ^redirect_pc[1:0];

  assign imem_req_valid = !redirect_valid && (({1'b0, inflight} + {1'b0, count}) < CAP);
  assign imem_req_addr  = fetchPc;
  assign accept         = imem_req_valid && imem_req_ready;
  assign respKeep       = imem_resp_valid && (discard == '0) && !redirect_valid;
  assign pop            = !redirect_valid && !stall && (count != '0);

  // With no stale responses pending, outstanding requests are consecutive words ending at fetchPc-4.
  assign respPc = fetchPc - (XLEN'(inflight) << 2);

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (XLEN + 32)
  ) fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (respKeep),
    .pushData ({respPc, imem_resp_data}),
    .pop      (pop),
    .flush    (redirect_valid),
    .headData (headData),
    .count    (count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      fetchPc  <= RESET_PC;
      inflight <= '0;
      discard  <= '0;
    end else begin
      if (redirect_valid)  fetchPc <= {redirect_pc[XLEN-1:2], 2'b00};
      else if (accept)     fetchPc <= fetchPc + XLEN'(4);
      inflight <= inflight + CW'(accept) - CW'(imem_resp_valid);
      // Every request still outstanding after a redirect returns a stale word.
      if (redirect_valid)
        discard <= inflight - CW'(imem_resp_valid);
      else if (imem_resp_valid && (discard != '0))
        discard <= discard - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ifid_ir    <= NOP;
      ifid_pc    <= RESET_PC;
      ifid_valid <= 1'b0;
    end else if (redirect_valid) begin
      ifid_ir    <= NOP;
      ifid_valid <= 1'b0;
    end else if (!stall) begin
      if (count != '0) begin
        ifid_pc    <= headData[XLEN+31:32];
        ifid_ir    <= headData[31:0];
        ifid_valid <= 1'b1;
      end else begin
        ifid_ir    <= NOP;
        ifid_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Randomised scoreboard bench for riscv_fetch_queue with a variable-latency instruction memory model.
module tb_riscv_fetch_queue;

  import riscv_pkg::*;

  localparam int              DEPTH    = 4;
  localparam int              XL       = 64;
  localparam logic [XL-1:0]   RESET_PC = '0;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           imem_req_valid;
  logic [XL-1:0]  imem_req_addr;
  logic           imem_req_ready = 1'b0;
  logic           imem_resp_valid = 1'b0;
  logic [31:0]    imem_resp_data = '0;
  logic           stall = 1'b0;
  logic           redirect_valid = 1'b0;
  logic [XL-1:0]  redirect_pc = '0;
  logic [31:0]    ifid_ir;
  logic [XL-1:0]  ifid_pc;
  logic           ifid_valid;

  riscv_fetch_queue #(.DEPTH(DEPTH), .XLEN(XL), .RESET_PC(RESET_PC)) dut (
    .clock           (clock),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .ifid_ir         (ifid_ir),
    .ifid_pc         (ifid_pc),
    .ifid_valid      (ifid_valid)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [XL-1:0] addr;
    int            dueCycle;
    bit            stale;
  } memReq_t;

  memReq_t        memQ[$];
  logic [XL-1:0]  expQ[$];
  int             checks = 0;
  int             errors = 0;
  int             cyc = 0;
  int             nonstaleOut = 0;
  logic [XL-1:0]  modelPc = RESET_PC;

  int readyPct = 100, latMin = 1, latMax = 1, stallPct = 0, redirPct = 0;
  int expectValid = -1;

  bit             capAccept, capResp, capRedir, capReset, capIfidValid;
  logic [XL-1:0]  capAddr, capTarget, capIfidPc;

  task automatic checkOutput(input string name, input logic [XL-1:0] actual, input logic [XL-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  // One clock of stimulus: sample handshakes mid-cycle, update the model after the edge, drive the next inputs.
  task automatic applyStimulus(input bit forceReset, input bit forceRedir, input logic [XL-1:0] forceTarget,
                               input bit forceStall);
    logic [XL-1:0] target;
    int lat;
    @(negedge clock);
    capAccept    = imem_req_valid && imem_req_ready;
    capAddr      = imem_req_addr;
    capResp      = imem_resp_valid;
    capRedir     = redirect_valid;
    capTarget    = redirect_pc;
    capReset     = reset;
    capIfidValid = ifid_valid;
    capIfidPc    = ifid_pc;
    if (expectValid >= 0) checkOutput("ifidValid", ifid_valid, XL'(expectValid));
    if (!reset && redirect_valid) checkOutput("noReqOnRedirect", imem_req_valid, 0);

    @(posedge clock);
    #1;
    cyc++;
    if (capReset) begin
      memQ.delete();
      expQ.delete();
      nonstaleOut = 0;
      modelPc = RESET_PC;
    end else begin
      if (capResp && memQ.size() > 0) begin
        if (!memQ[0].stale) nonstaleOut--;
        void'(memQ.pop_front());
      end
      if (capRedir) begin
        foreach (memQ[i]) memQ[i].stale = 1'b1;
        nonstaleOut = 0;
        expQ.delete();
        modelPc = {capTarget[XL-1:2], 2'b00};
      end else if (capAccept) begin
        checkOutput("reqAddr", capAddr, modelPc);
        lat = $urandom_range(latMax, latMin);
        memQ.push_back('{addr: capAddr, dueCycle: cyc + lat - 1, stale: 1'b0});
        nonstaleOut++;
        expQ.push_back(modelPc);
        modelPc = modelPc + 4;
      end
    end

    reset = forceReset;
    stall = forceStall || ($urandom_range(99) < stallPct);
    redirect_valid = forceRedir || (!forceReset && ($urandom_range(99) < redirPct));
    target = {32'h0, 32'($urandom_range(32'hffff))};
    if ($urandom_range(7) == 0) target = {32'hFFFF_FFFF, 32'hFFFF_FFE0 | 32'($urandom_range(31))};
    redirect_pc = forceRedir ? forceTarget : target;
    imem_req_ready = ($urandom_range(99) < readyPct);
    if (!reset && memQ.size() > 0 && memQ[0].dueCycle <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = memQ[0].addr[31:0];
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
  endtask

  // Monitor: checks the IF/ID register produced by the previous edge against the expected instruction stream.
  logic [31:0]   lastIr = NOP;
  logic [XL-1:0] lastPc = RESET_PC;
  logic          lastValid = 1'b0;
  bit            prevReset = 1'b1, prevRedir = 1'b0, prevStall = 1'b0;

  always @(negedge clock) begin
    int total;
    logic [XL-1:0] e;
    if (prevReset) begin
      checkOutput("resetIr", ifid_ir, NOP);
      checkOutput("resetPc", ifid_pc, RESET_PC);
      checkOutput("resetValid", ifid_valid, 0);
    end else if (prevRedir) begin
      checkOutput("redirIr", ifid_ir, NOP);
      checkOutput("redirValid", ifid_valid, 0);
      checkOutput("redirPcHold", ifid_pc, lastPc);
    end else if (prevStall) begin
      checkOutput("stallIr", ifid_ir, lastIr);
      checkOutput("stallPc", ifid_pc, lastPc);
      checkOutput("stallValid", ifid_valid, lastValid);
    end else if (ifid_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedDelivery", ifid_valid, 0);
      end else begin
        e = expQ.pop_front();
        checkOutput("ifidPc", ifid_pc, e);
        checkOutput("ifidIr", ifid_ir, XL'(e[31:0]));
      end
    end else begin
      checkOutput("emptyIr", ifid_ir, NOP);
      checkOutput("emptyPcHold", ifid_pc, lastPc);
    end
    total = memQ.size() + expQ.size() - nonstaleOut;
    checkOutput("reqValid", imem_req_valid, XL'(!redirect_valid && (total < DEPTH)));
    lastIr    = ifid_ir;
    lastPc    = ifid_pc;
    lastValid = ifid_valid;
    prevReset = reset;
    prevRedir = redirect_valid;
    prevStall = stall;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waitN;
    // Zero-wait memory: 3-cycle fill, then one instruction per cycle, with a 3-cycle stall in the stream.
    readyPct = 100; latMin = 1; latMax = 1;
    for (int i = 1; i <= 40; i++) begin
      expectValid = (i < 7) ? -1 : ((i == 7) ? 0 : 1);
      applyStimulus(i <= 3, 0, '0, (i >= 10) && (i <= 12));
    end
    expectValid = -1;

    // Memory not ready for 5 cycles after reset, then in-order resumption from RESET_PC.
    repeat (2) applyStimulus(1, 0, '0, 0);
    readyPct = 0;
    expectValid = 0;
    repeat (5) applyStimulus(0, 0, '0, 0);
    expectValid = -1;
    readyPct = 100;
    repeat (15) applyStimulus(0, 0, '0, 0);

    // Three-cycle response latency, then a redirect to 0x103 with requests in flight.
    latMin = 3; latMax = 3;
    repeat (20) applyStimulus(0, 0, '0, 0);
    applyStimulus(0, 1, 64'h103, 0);
    applyStimulus(0, 0, '0, 0);
    waitN = 0;
    do begin
      applyStimulus(0, 0, '0, 0);
      waitN++;
    end while (!capIfidValid && waitN < 20);
    checkOutput("redirectFirstPc", capIfidPc, 64'h100);

    // Fully random traffic: ready, latency, stalls and redirects.
    readyPct = 70; latMin = 1; latMax = 4; stallPct = 20; redirPct = 5;
    repeat (800) applyStimulus(0, 0, '0, 0);

    // Redirect together with a stall, then a reset in mid-stream.
    latMin = 1; latMax = 1; readyPct = 100; stallPct = 0; redirPct = 0;
    repeat (6) applyStimulus(0, 0, '0, 0);
    applyStimulus(0, 1, 64'h200, 1);
    repeat (4) applyStimulus(0, 0, '0, 0);
    repeat (2) applyStimulus(1, 0, '0, 0);
    readyPct = 80; latMin = 1; latMax = 3; stallPct = 15; redirPct = 3;
    repeat (60) applyStimulus(0, 0, '0, 0);

    // Drain: stop issuing and let every accepted instruction reach IF/ID.
    readyPct = 0; stallPct = 0; redirPct = 0;
    waitN = 0;
    while ((expQ.size() != 0 || redirect_valid || stall) && waitN < 100) begin
      applyStimulus(0, 0, '0, 0);
      waitN++;
    end
    repeat (2) applyStimulus(0, 0, '0, 0);
    checkOutput("drain", XL'(expQ.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_fetch_queue.md
# riscv_fetch_queue

Instruction-fetch front end for the five-stage RISC-V pipeline. Issues in-order word fetches to an instruction memory port with variable latency and buffers returned instructions in a small prefetch queue. Delivers one instruction per cycle into the IF/ID pipeline register. Decode-stage stalls freeze delivery, and taken branches redirect the fetch PC and flush stale instructions, with a NOP (`0x0000_0013`) injected into IF/ID.

## Interface
- `DEPTH`, 4: prefetch queue entries; also the cap on queued plus in-flight fetches; power of two, ≥2
- `XLEN`, 64: PC width
- `RESET_PC`, 0: fetch PC after reset
- `clock` in 1: single clock; all state updates on the rising edge
- `reset` in 1: synchronous, active-high
- `imem_req_valid` out 1: fetch request valid
- `imem_req_addr` out XLEN: byte address of the fetched word; bits [1:0] always 0
- `imem_req_ready` in 1: memory accepts the request this cycle
- `imem_resp_valid` in 1: response valid; in request order, never earlier than the cycle after acceptance
- `imem_resp_data` in 32: returned instruction word
- `stall` in 1: load-use hazard; hold IF/ID
- `redirect_valid` in 1: taken branch in ID
- `redirect_pc` in XLEN: branch target; bits [1:0] ignored
- `ifid_ir` out 32: IF/ID instruction register
- `ifid_pc` out XLEN: PC of `ifid_ir`
- `ifid_valid` out 1: 0 when `ifid_ir` is an injected NOP

## Operation
- State:
  - `fetch_pc`
  - circular queue of {pc, instr} with head/tail pointers and `count` (0..DEPTH)
  - `inflight`: accepted requests not yet answered, 0..DEPTH
  - `discard`: stale responses still to drop, ≤ `inflight`
- Request: `imem_req_valid = !redirect_valid && (inflight + count < DEPTH)`.
  - `imem_req_addr = fetch_pc`.
  - On accept (valid && ready): `fetch_pc += 4`, `inflight++`.
  - Each request's PC is pushed onto a side PC queue, or recomputed from the tail.
- Response:
  - `inflight--` on every response.
  - If `discard > 0`: drop the response and decrement `discard`.
  - Otherwise push {pc, data} at the tail.
  - The queue cannot overflow, because of the credit rule.
- Delivery, when `stall` = 0 and `redirect_valid` = 0:
  - If `count > 0`: pop the head into `ifid_ir`/`ifid_pc` with `ifid_valid` = 1.
  - Else load NOP with `ifid_valid` = 0; `ifid_pc` holds its value.
- Stall, with `redirect_valid` = 0: `ifid_*` hold. Fetch and response capture continue while credits allow.
- Redirect (wins over `stall` and over a same-cycle response or pop):
  - `fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}`.
  - Queue emptied (`count` = 0).
  - `discard <= inflight - (imem_resp_valid ? 1 : 0)`, counting all outstanding requests including any pre-existing discard.
  - `ifid_ir <= NOP`, `ifid_valid <= 0`.
  - No request is issued this cycle.
- Reset: the rules below apply; an in-progress redirect or outstanding fetch is abandoned. The memory is reset in the same cycle, so no stale responses arrive.
- Counter widths: `$clog2(DEPTH+1)`. PC increment wraps modulo 2^XLEN.

## Timing
- Reset values:
  - `fetch_pc = RESET_PC`; `count`, `inflight`, `discard` = 0
  - `ifid_ir = 0x0000_0013`, `ifid_pc = RESET_PC`, `ifid_valid = 0`
  - `imem_req_valid` = 1 in the first cycle after reset deasserts
- Latency: a response in cycle N is written to the queue at the end of N and appears in `ifid_ir` at the end of N+1 at the earliest. There is no response-to-IF/ID bypass.
- Zero-wait memory (ready = 1, response the cycle after acceptance): steady throughput of 1 instruction/cycle after a 3-cycle fill.
- First post-redirect instruction: request in cycle R+1, response ≥ R+2, `ifid` ≥ end of R+3.
- Full: `inflight + count == DEPTH` → `imem_req_valid` = 0 until a pop.
- Simultaneous pop and push: allowed; `count` unchanged. With pointer wrap at DEPTH-1 → 0, the order is preserved.

## Structure
- A shared `riscv_pkg` package holds `NOP = 32'h0000_0013`, the opcode constants, and `XLEN`, reused by the CPU.
- One sub-module, `fetch_fifo`: a parameterised synchronous FIFO with push/pop/flush and count, holding {pc, instr}.
- The top level holds `fetch_pc`, the credit, inflight and discard counters, and the IF/ID registers.

## Test plan
- Reset, then zero-wait memory returning `IMem[a>>2] = a` → `ifid_pc` = 0, 4, 8… on consecutive cycles, with `ifid_ir == ifid_pc[31:0]`.
- Hold `imem_req_ready` = 0 for 5 cycles → `ifid_valid` = 0 with NOP; then in-order resumption starting at PC 0.
- Responses delayed 3 cycles with DEPTH = 4 → `inflight + count` never exceeds 4; no instruction lost or duplicated.
- `stall` = 1 for 3 cycles at `ifid_pc` = 8 → `ifid_pc`/`ifid_ir` hold at 8, `count` reaches 4, then 12, 16… follow with no gap.
- `redirect_valid` with `redirect_pc` = 0x103 while 2 requests are in flight → `ifid_ir` = NOP next cycle, both stale responses dropped, next valid `ifid_pc` = 0x100.
- Redirect coincident with a response and `stall` = 1; `reset` asserted mid-stream → response dropped and redirect honoured; after reset all outputs hold their reset values.
